dmem_wait_ctrl: RTL

Data-memory responder for the MEM stage's request/ready handshake: accepts a word read or write, inserts a parameterised number of wait states, then pulses `mem_ready` for one cycle with read data or a committed write. It sits opposite the MEM-stage initiator, whose stall is `(mem_read || mem_write) && !mem_ready`. It replaces the zero-wait data memory when the pipeline is exercised under realistic memory latency.

---
 rtl/dmem_wait_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmem_wait_ctrl.sv
// Data-memory responder for the MEM-stage request/ready handshake.
// Each access takes a fixed latency, then mem_ready pulses for one cycle.
module dmem_wait_ctrl #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // cnt holds the number of WAIT cycles still to spend, so a latency of 1 skips WAIT
  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                is_write_q, is_write_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                mem_ready_q, mem_ready_d;

  logic [31:0]         mem [2**ADDR_W];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_widx;
  logic [31:0]         mem_wdata;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_idx;
  logic [3:0]          req_cnt;

  logic                req;
  logic [ADDR_W-1:0]   req_idx;
  logic                unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign req_idx          = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign req_cnt          = mem_write ? WR_CNT : RD_CNT;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mem_ready_d = 1'b0;
    mem_we      = 1'b0;
    mem_widx    = idx_q;
    mem_wdata   = wdata_q;
    rd_en       = 1'b0;
    rd_idx      = idx_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          is_write_d = mem_write;
          idx_d      = req_idx;
          if (mem_write) begin
            wdata_d = wdata;
          end
          if (req_cnt == 4'd0) begin
            state_d     = DONE;
            mem_ready_d = 1'b1;
            cnt_d       = 4'd0;
            if (mem_write) begin
              mem_we    = 1'b1;
              mem_widx  = req_idx;
              mem_wdata = wdata;
            end else begin
              rd_en  = 1'b1;
              rd_idx = req_idx;
            end
          end else begin
            state_d = WAIT;
            cnt_d   = req_cnt;
          end
        end
      end

      WAIT: begin
        // Withdrawal takes priority, so an abort on the final WAIT cycle commits nothing
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d     = DONE;
          mem_ready_d = 1'b1;
          cnt_d       = 4'd0;
          if (is_write_q) begin
            mem_we = 1'b1;
          end else begin
            rd_en = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      is_write_q  <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  // Array is never cleared; a commit edge that coincides with reset is dropped
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  assign rdata     = rdata_q;
  assign mem_ready = mem_ready_q;
  assign busy      = (state_q == WAIT);

endmodule
